io_priority_arb: RTL and testbench
==================================

Name: io_priority_arb

Overview:
- Parametrised successor to the 3-line IO priority block on the memory board.
- Arbitrates N request lines onto N bidirectional pads; at most one pad is driven at any time.
- Enforces a minimum hold time per grant and a break-before-make dead time between grants, so two pads are never driven at once.
- Selectable fixed-priority or round-robin arbitration; returns synchronised pad readback to the controller.

Parameters:
- N, 3, number of channels (request lines / pads), 2..16
- HOLD, 4, minimum cycles a grant stays driven, >=1
- DEAD, 2, cycles all pads tri-stated between grants; 0 = direct IDLE/DRIVE transition, no gap
- SYNC, 2, pad readback synchroniser stages, >=2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N  channel request lines, level-sensitive
- mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin
- drv_val  input  1  level driven onto the granted pad
- pad  inout  N  bidirectional pads; only the granted pad is driven, all others Z
- grant  output  N  registered one-hot grant; all-zero when nothing is driven
- busy  output  1  high in DRIVE or DEAD
- pad_in  output  N  pad values after SYNC flops
- fault  output  1  sticky contention flag; tied 0 without the optional feature

Behaviour:
- Reset (async assert, sync release):
  - grant=0, all pads Z immediately.
  - busy=0, pad_in=0, fault=0, state=IDLE, hold counter=0, dead counter=0.
  - drv_q=0; rr_ptr=N-1, so the first round-robin search starts at channel 0.
- Pad drive: pad[i] = grant[i] ? drv_q : Z. drv_q is drv_val registered every cycle, so there is 1 cycle latency from drv_val to pad.
- Winner selection (combinational):
  - mode=0: lowest set index of req.
  - mode=1: first set req searching from rr_ptr+1 upward with wrap.
  - mode is sampled only at selection time.
- IDLE:
  - If any req is set: grant <= onehot(winner), hold=0, next state DRIVE. Grant appears on the edge that samples req (1-cycle latency).
  - Otherwise stay in IDLE.
- DRIVE:
  - hold counter increments and saturates at HOLD-1.
  - Release occurs when hold==HOLD-1 and any of the following holds:
    - the granted req is low;
    - mode=0 and a higher-priority req is set;
    - mode=1 and any other req is set.
  - On release: grant <= 0, rr_ptr <= granted index, then go to DEAD (DEAD>0) or re-select immediately as in IDLE (DEAD=0).
  - A req that drops before HOLD expires does not shorten the grant; the pad stays driven for the full HOLD cycles.
- DEAD:
  - All pads Z for exactly DEAD cycles.
  - Then: if any req is set, select a winner and go to DRIVE; else go to IDLE.
  - Requests arriving during DEAD are not lost; req is level-sensitive and is re-sampled at exit.
- Simultaneous requests: exactly one winner per selection; grant is never multi-hot.
- busy = (state != IDLE).
- pad_in: each bit passes through SYNC flops; reset value 0.
- Counter widths: clog2(max(HOLD,DEAD,2)) bits. No wrap, because counters saturate or clear on state entry.
- Reset mid-DRIVE: pad goes Z asynchronously; no DEAD phase is inserted after reset release.

Optional Feature:
- Macro: IO_PRIORITY_CONTENTION_EN.
- Defined:
  - While in DRIVE, once hold >= SYNC, compare pad_in[granted] with drv_q delayed by SYNC cycles.
  - On mismatch: set fault (sticky until rst_n), force release into DEAD, and ignore further requests. The block stays IDLE until reset.
- Undefined: fault is tied 0, no comparison logic is built, and arbitration is unaffected.

Test Plan:
- Reset: rst_n=0 mid-DRIVE with grant=3'b010 -> pad=3'bZZZ the same cycle; after release grant=0, busy=0, fault=0.
- Fixed priority, N=3: req=3'b110 then 3'b111 at cycle 1 of DRIVE -> grant=3'b010 held for 4 cycles, then 0 for 2 cycles, then grant=3'b001.
- Short request: req[2] pulsed for 1 cycle in IDLE -> grant=3'b100 for exactly 4 cycles, pad[2]=drv_val (1-cycle lag), then 2 Z cycles, then IDLE.
- Round-robin: mode=1, req=3'b111 held -> grant sequence 001,010,100,001, each 4 cycles driven with 2 cycles all-Z between; never two grant bits high.
- DEAD=0 instance: req=3'b011 held with mode=1 -> grant switches 001 to 010 on consecutive cycles with no zero cycle between.
- IO_PRIORITY_CONTENTION_EN: pad[0] forced 0 externally while granted with drv_val=1 -> fault=1 at hold=SYNC, grant=0 after DEAD, stays idle until rst_n pulse.

Source files
------------

// File: rtl/io_priority_arb_if.sv
// io_priority_arb_if
//   Groups the controller-side signals of io_priority_arb.
//   master: drives req/mode/drv_val and observes grant/busy/pad_in/fault.
//   slave : the arbiter side.
//   The bidirectional pads stay a plain inout port on the arbiter.
interface io_priority_arb_if #(
  parameter int N = 3
);
  logic [N-1:0] req;      // level-sensitive request lines
  logic         mode;     // 0 = fixed priority, 1 = round-robin
  logic         drv_val;  // level driven onto the granted pad
  logic [N-1:0] grant;    // registered one-hot grant
  logic         busy;     // DRIVE or DEAD
  logic [N-1:0] pad_in;   // synchronised pad readback
  logic         fault;    // sticky contention flag

  modport master (output req, mode, drv_val, input grant, busy, pad_in, fault);
  modport slave  (input req, mode, drv_val, output grant, busy, pad_in, fault);
endinterface

// File: rtl/io_priority_arb.sv
// io_priority_arb
//   Arbitrates N request lines onto N bidirectional pads. At most one pad is
//   driven at a time; each grant lasts at least HOLD cycles and DEAD all-Z
//   cycles separate consecutive grants (DEAD=0 switches back to back).
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - io_priority_arb_if.slave (req, mode, drv_val, grant, busy,
//              pad_in, fault)
//     pad    - N bidirectional pads, only the granted one driven
//   Optional feature macro: IO_PRIORITY_CONTENTION_EN
//     When defined, the readback of the granted pad is compared against the
//     value driven SYNC cycles earlier; a mismatch sets a sticky fault,
//     releases the pad and locks the arbiter idle until reset.
module io_priority_arb #(
  parameter int N    = 3,
  parameter int HOLD = 4,
  parameter int DEAD = 2,
  parameter int SYNC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  io_priority_arb_if.slave bus,
  inout  wire  [N-1:0]     pad
);
  localparam int MX = (HOLD > DEAD) ? HOLD : DEAD;
  localparam int CW = (MX > 2) ? $clog2(MX) : 1;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DEAD} state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [CW-1:0]        hold_q, hold_d;
  logic [CW-1:0]        dead_q, dead_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic                 drv_q;
  logic [SYNC-1:0][N-1:0] sync_q;

  logic                 mism;
  logic                 flt;

  // Pad drive and readback
  for (genvar i = 0; i < N; i++) begin : g_pad
    assign pad[i] = grant_q[i] ? drv_q : 1'bz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      drv_q  <= bus.drv_val;
      sync_q <= {sync_q[SYNC-2:0], pad};
    end
  end

  assign bus.pad_in = sync_q[SYNC-1];
  assign bus.grant  = grant_q;
  assign bus.busy   = (state_q != S_IDLE);

`ifdef IO_PRIORITY_CONTENTION_EN
  // drv_q aligned with what pad_in shows now (pad_in lags the pad by SYNC)
  logic [SYNC-1:0] dly_q;
  logic            fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      dly_q   <= {dly_q[SYNC-2:0], drv_q};
      fault_q <= fault_q | mism;
    end
  end

  assign mism      = (state_q == S_DRIVE) && (int'(hold_q) >= SYNC) &&
                     (bus.pad_in[gidx_q] != dly_q[SYNC-1]);
  assign flt       = fault_q;
  assign bus.fault = fault_q;
`else
  assign mism      = 1'b0;
  assign flt       = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // Winner selection. During DRIVE the only selection is the DEAD=0
  // back-to-back case, where the search must start after the channel just
  // released, i.e. the pointer value being written this cycle.
  logic [IW-1:0] base;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          win_vld;

  assign base = (state_q == S_DRIVE) ? gidx_q : rr_q;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    if (!bus.mode) begin
      // descending scan so the lowest set index wins
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.req[i]) begin
          win     = IW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      // descending over search distance so the nearest after base wins
      for (int k = N; k >= 1; k--) begin
        cand = IW'((int'(base) + k) % N);
        if (bus.req[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Release condition, only acted on once the hold time is met.
  // grant_q is one-hot, so grant_q-1 masks exactly the higher-priority lines.
  logic own_req, hi_req, oth_req, rel;
  assign own_req = |(bus.req & grant_q);
  assign hi_req  = |(bus.req & (grant_q - N'(1)));
  assign oth_req = |(bus.req & ~grant_q);
  assign rel     = (hold_q == CW'(HOLD - 1)) &&
                   (!own_req || (!bus.mode && hi_req) || (bus.mode && oth_req));

  logic go;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    go      = 1'b0;
    case (state_q)
      S_IDLE: go = 1'b1;
      S_DRIVE: begin
        if (hold_q != CW'(HOLD - 1)) hold_d = hold_q + CW'(1);
        if (mism || rel) begin
          grant_d = '0;
          rr_d    = gidx_q;
          hold_d  = '0;
          dead_d  = '0;
          if (mism)          state_d = (DEAD > 0) ? S_DEAD : S_IDLE;
          else if (DEAD > 0) state_d = S_DEAD;
          else               go      = 1'b1;
        end
      end
      S_DEAD: begin
        if (dead_q == CW'(DEAD - 1)) go     = 1'b1;
        else                         dead_d = dead_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      // a latched fault ignores all further requests
      if (win_vld && !flt) begin
        grant_d = N'(1) << win;
        gidx_d  = win;
        hold_d  = '0;
        state_d = S_DRIVE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      dead_q  <= '0;
      rr_q    <= IW'(N - 1);
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
    end
  end
endmodule

// File: tb/tb_io_priority_arb.sv
module tb_io_priority_arb;
  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         drv_val = 1'b0;

  io_priority_arb_if #(.N(N)) ifa ();
  io_priority_arb_if #(.N(N)) ifb ();
  assign ifa.req = req;  assign ifa.mode = mode;  assign ifa.drv_val = drv_val;
  assign ifb.req = req;  assign ifb.mode = mode;  assign ifb.drv_val = drv_val;

  wire [N-1:0] pad_a;
  wire [N-1:0] pad_b;

  // a: default DEAD=2, b: DEAD=0 back-to-back switching
  io_priority_arb #(.N(N), .HOLD(HOLD), .DEAD(2), .SYNC(SYNC)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .pad(pad_a));
  io_priority_arb #(.N(N), .HOLD(HOLD), .DEAD(0), .SYNC(SYNC)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .pad(pad_b));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: granted channel or -1; held: cycles driven so far;
  // gap: all-Z cycles still to go; ptr: last released channel.
  int   owner[2], held[2], gap[2], ptr[2];
  int   deadp[2] = '{2, 0};
  logic mdrv[2];
  bit   chk_en[2] = '{1'b1, 1'b1};
  logic [N-1:0] hv[2][SYNC];
  logic [N-1:0] hm[2][SYNC];

  function automatic int pick(input int j);
    int best = -1;
    int bd = N + 1;
    int d;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = mode ? ((i - ptr[j] - 1 + 2 * N) % N) : i;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic mstep(input int j);
    bit sel = 1'b0;
    int o;
    if (owner[j] >= 0) begin
      o = owner[j];
      held[j]++;
      if (held[j] >= HOLD &&
          (!req[o] ||
           (!mode && (int'(req) & ((1 << o) - 1)) != 0) ||
           ( mode && (int'(req) & ~(1 << o)) != 0))) begin
        ptr[j]   = o;
        owner[j] = -1;
        if (deadp[j] > 0) gap[j] = deadp[j];
        else              sel = 1'b1;
      end
    end else if (gap[j] > 0) begin
      gap[j]--;
      sel = (gap[j] == 0);
    end else begin
      sel = 1'b1;
    end
    if (sel) begin
      owner[j] = pick(j);
      held[j]  = 0;
    end
    mdrv[j] = drv_val;
  endtask

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        owner[j] = -1; held[j] = 0; gap[j] = 0; ptr[j] = N - 1; mdrv[j] = 1'b0;
      end else begin
        mstep(j);
      end
    end
  end

  task automatic cmp(input int j, input logic [N-1:0] g, input logic b,
                     input logic [N-1:0] p, input logic [N-1:0] pi);
    logic [N-1:0] eg;
    string pre;
    pre = (j == 0) ? "a_" : "b_";
    eg = (owner[j] >= 0) ? N'(1) << owner[j] : '0;
    if (chk_en[j]) begin
      chk({pre, "grant"}, 32'(g), 32'(eg));
      chk({pre, "busy"}, 32'(b), 32'(owner[j] >= 0 || gap[j] > 0));
      chk({pre, "onehot"}, 32'($countones(g) <= 1), 32'd1);
      if (owner[j] >= 0) chk({pre, "pad"}, 32'(p[owner[j]]), 32'(mdrv[j]));
      for (int i = 0; i < N; i++)
        if (hm[j][SYNC-1][i]) chk({pre, "pad_in"}, 32'(pi[i]), 32'(hv[j][SYNC-1][i]));
    end
    for (int k = SYNC - 1; k >= 1; k--) begin
      hv[j][k] = hv[j][k-1];
      hm[j][k] = hm[j][k-1];
    end
    hm[j][0] = eg;
    hv[j][0] = {N{mdrv[j]}} & eg;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < SYNC; k++) begin hv[j][k] = '0; hm[j][k] = '0; end
    end else begin
      cmp(0, ifa.grant, ifa.busy, pad_a, ifa.pad_in);
      cmp(1, ifb.grant, ifb.busy, pad_b, ifb.pad_in);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_seq(input string nm, input logic [N-1:0] q[$], input bit b);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk(nm, 32'(b ? ifb.grant : ifa.grant), 32'(q[i]));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifa.busy || ifb.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  logic [N-1:0] seq[$];

  initial begin
    // reset mid-DRIVE
    do_reset();
    mode = 1'b0; req = 3'b010;
    @(negedge clk);
    chk("rst_pre_grant", 32'(ifa.grant), 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_grant_async", 32'(ifa.grant), 32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'h0);
    chk("rst_fault", 32'(ifa.fault), 32'h0);
    chk("rst_pad_in", 32'(ifa.pad_in), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_grant", 32'(ifa.grant), 32'h0);
    chk("rel_busy", 32'(ifa.busy), 32'h0);
    chk("rel_fault", 32'(ifa.fault), 32'h0);
    @(negedge clk);
    chk("rel_no_dead", 32'(ifa.grant), 32'h2);
    req = '0;
    wait_idle();

    // fixed priority with a higher request arriving during the hold
    do_reset();
    mode = 1'b0; req = 3'b110;
    @(negedge clk);
    chk("fix_first", 32'(ifa.grant), 32'h2);
    req = 3'b111;
    seq = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001};
    expect_seq("fix_seq", seq, 1'b0);
    req = '0;
    wait_idle();

    // one-cycle request still gets the full hold
    do_reset();
    mode = 1'b0; drv_val = 1'b1; req = 3'b100;
    @(negedge clk);
    chk("short_grant", 32'(ifa.grant), 32'h4);
    chk("short_pad", 32'(pad_a[2]), 32'h1);
    req = '0;
    drv_val = 1'b0;
    #1;
    chk("short_pad_lag", 32'(pad_a[2]), 32'h1);
    seq = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
    expect_seq("short_seq", seq, 1'b0);
    @(negedge clk);
    chk("short_idle", 32'(ifa.busy), 32'h0);

    // round-robin with all requests held
    do_reset();
    mode = 1'b1; drv_val = 1'b1; req = 3'b111;
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
            3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
            3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001};
    expect_seq("rr_seq", seq, 1'b0);
    req = '0;
    wait_idle();

    // DEAD=0 instance switches on consecutive cycles
    do_reset();
    mode = 1'b1; req = 3'b011;
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
    expect_seq("dead0_seq", seq, 1'b1);
    drv_val = 1'b0;
    req = '0;
    wait_idle();

`ifdef IO_PRIORITY_CONTENTION_EN
    do_reset();
    chk_en[0] = 1'b0;
    mode = 1'b0; drv_val = 1'b1;
    force pad_a[0] = 1'b0;
    req = 3'b001;
    @(negedge clk);
    chk("ct_grant", 32'(ifa.grant), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("ct_fault_pre", 32'(ifa.fault), 32'h0);
    @(negedge clk);
    chk("ct_fault", 32'(ifa.fault), 32'h1);
    chk("ct_release", 32'(ifa.grant), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("ct_idle", 32'(ifa.busy), 32'h0);
    repeat (5) begin
      @(negedge clk);
      chk("ct_locked", 32'(ifa.grant), 32'h0);
      chk("ct_sticky", 32'(ifa.fault), 32'h1);
    end
    release pad_a[0];
    do_reset();
    #1;
    chk("ct_fault_clr", 32'(ifa.fault), 32'h0);
    chk_en[0] = 1'b1;
    req = '0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
